// File: rtl/utopia1_atm_rx_if.sv
// rtl/utopia1_atm_rx_if.sv - UTOPIA level 1 receive byte bus and assembled-cell handshake
interface utopia1_atm_rx_if;
    logic         clav;
    logic         en;
    logic         soc;
    logic [7:0]   data;
    logic         valid;
    logic         ready;
    logic [11:0]  vpi;
    logic [15:0]  vci;
    logic         clp;
    logic [2:0]   pt;
    logic [7:0]   hec;
    logic [383:0] payload;
    logic         hec_err;
    logic         sync_err;

    modport slave (
        output clav,
        input  en,
        input  soc,
        input  data,
        output valid,
        input  ready,
        output vpi,
        output vci,
        output clp,
        output pt,
        output hec,
        output payload,
        output hec_err,
        output sync_err
    );

    modport master (
        input  clav,
        output en,
        output soc,
        output data,
        input  valid,
        output ready,
        input  vpi,
        input  vci,
        input  clp,
        input  pt,
        input  hec,
        input  payload,
        input  hec_err,
        input  sync_err
    );
endinterface

// File: rtl/utopia1_atm_rx.sv
// rtl/utopia1_atm_rx.sv - UTOPIA level 1 ATM cell receiver with HEC check and resync
module utopia1_atm_rx #(
    parameter logic [7:0] HEC_COSET = 8'h55,
    parameter bit         HEC_CHECK = 1'b1
) (
    input  logic             clk_in,
    input  logic             reset_n,
    utopia1_atm_rx_if.slave  u
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [7:0]   crc_q, crc_d;
    logic         clav_q, clav_d;
    logic         valid_q, valid_d;
    logic         hec_err_q, hec_err_d;
    logic         sync_err_q, sync_err_d;
    logic [11:0]  vpi_q, vpi_d;
    logic [15:0]  vci_q, vci_d;
    logic         clp_q, clp_d;
    logic [2:0]   pt_q, pt_d;
    logic [7:0]   hec_q, hec_d;
    logic [383:0] payload_q, payload_d;

    logic         accept;
    logic [5:0]   byte_rev;
    logic [8:0]   byte_lo;

    // CRC-8, polynomial x^8+x^2+x+1, one byte MSB first
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] din);
        logic [7:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ din[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else               c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign accept   = ~u.en;
    // Payload byte cnt-5 lands at bit 8*(52-cnt), so byte 0 is the MSB byte
    assign byte_rev = 6'd52 - cnt_q;
    assign byte_lo  = {byte_rev, 3'b000};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        valid_d    = valid_q;
        hec_err_d  = hec_err_q;
        sync_err_d = 1'b0;
        vpi_d      = vpi_q;
        vci_d      = vci_q;
        clp_d      = clp_q;
        pt_d       = pt_q;
        hec_d      = hec_q;
        payload_d  = payload_q;

        case (state_q)
            IDLE: begin
                if (accept && u.soc) begin
                    state_d     = HEADER;
                    cnt_d       = 6'd1;
                    crc_d       = crc8_step(8'h00, u.data);
                    vpi_d[11:4] = u.data;
                end
            end
            HEADER, PAYLOAD: begin
                if (accept && u.soc) begin
                    sync_err_d  = 1'b1;
                    state_d     = HEADER;
                    cnt_d       = 6'd1;
                    crc_d       = crc8_step(8'h00, u.data);
                    vpi_d[11:4] = u.data;
                end else if (accept && state_q == HEADER) begin
                    cnt_d = cnt_q + 6'd1;
                    case (cnt_q)
                        6'd1: begin
                            vpi_d[3:0]   = u.data[7:4];
                            vci_d[15:12] = u.data[3:0];
                            crc_d        = crc8_step(crc_q, u.data);
                        end
                        6'd2: begin
                            vci_d[11:4] = u.data;
                            crc_d       = crc8_step(crc_q, u.data);
                        end
                        6'd3: begin
                            vci_d[3:0] = u.data[7:4];
                            clp_d      = u.data[3];
                            pt_d       = u.data[2:0];
                            crc_d      = crc8_step(crc_q, u.data);
                        end
                        default: begin
                            hec_d   = u.data;
                            state_d = PAYLOAD;
                            cnt_d   = 6'd5;
                        end
                    endcase
                end else if (accept) begin
                    payload_d[byte_lo +: 8] = u.data;
                    if (cnt_q == 6'd52) state_d = DELIVER;
                    else                cnt_d   = cnt_q + 6'd1;
                end
            end
            DELIVER: begin
                // First DELIVER cycle raises valid; ready counts only once valid is up
                if (!valid_q) begin
                    valid_d   = 1'b1;
                    hec_err_d = HEC_CHECK && ((crc_q ^ HEC_COSET) != hec_q);
                end else if (u.ready) begin
                    valid_d   = 1'b0;
                    hec_err_d = 1'b0;
                    state_d   = IDLE;
                    cnt_d     = 6'd0;
                    crc_d     = 8'h00;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        clav_d = (state_d != DELIVER);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            crc_q      <= 8'h00;
            clav_q     <= 1'b0;
            valid_q    <= 1'b0;
            hec_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
            vpi_q      <= 12'h000;
            vci_q      <= 16'h0000;
            clp_q      <= 1'b0;
            pt_q       <= 3'b000;
            hec_q      <= 8'h00;
            payload_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            clav_q     <= clav_d;
            valid_q    <= valid_d;
            hec_err_q  <= hec_err_d;
            sync_err_q <= sync_err_d;
            vpi_q      <= vpi_d;
            vci_q      <= vci_d;
            clp_q      <= clp_d;
            pt_q       <= pt_d;
            hec_q      <= hec_d;
            payload_q  <= payload_d;
        end
    end

    assign u.clav     = clav_q;
    assign u.valid    = valid_q;
    assign u.hec_err  = hec_err_q;
    assign u.sync_err = sync_err_q;
    assign u.vpi      = vpi_q;
    assign u.vci      = vci_q;
    assign u.clp      = clp_q;
    assign u.pt       = pt_q;
    assign u.hec      = hec_q;
    assign u.payload  = payload_q;
endmodule

// File: doc/utopia1_atm_rx.md
UTOPIA1_ATM_RX -- requirements
Module: utopia1_atm_rx

Interface
REQ-001 SHALL have parameter HEC_COSET, default 8'h55, the value XORed into the computed header CRC before comparison.
REQ-002 SHALL have parameter HEC_CHECK, default 1; 1 = compare the received HEC, 0 = hec_err is held at 0.
REQ-003 SHALL have port clk_in  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port clav  output  1  cell space available; the far-end transmitter sends bytes only while it is 1.
REQ-006 SHALL have port en  input  1  active-low byte strobe from the transmitter; data and soc qualify only when en=0.
REQ-007 SHALL have port soc  input  1  start of cell; 1 with the first header byte.
REQ-008 SHALL have port data  input  8  cell byte.
REQ-009 SHALL have port valid  output  1  assembled cell is presented on the cell outputs.
REQ-010 SHALL have port ready  input  1  consumer accepts the presented cell.
REQ-011 SHALL have port vpi  output  12, port vci  output  16, port clp  output  1, port pt  output  3, port hec  output  8: the NNI header fields.
REQ-012 SHALL have port payload  output  384  payload bytes; byte 0 is at [383:376] and byte 47 at [7:0].
REQ-013 SHALL have port hec_err  output  1  header CRC mismatch for the presented cell; valid only while valid=1.
REQ-014 SHALL have port sync_err  output  1  one-cycle pulse when a partial cell is abandoned.

Function
REQ-015 SHALL implement the states IDLE, HEADER, PAYLOAD and DELIVER, with a 6-bit byte counter cnt.
REQ-016 SHALL accept a byte only at a rising edge where en=0; en=1 stalls the FSM with cnt held.
REQ-017 In IDLE, SHALL drive clav=1 and ignore accepted bytes with soc=0 (discarded silently, no error).
REQ-018 In IDLE, on an accepted byte with soc=1, SHALL store it as header byte 0, set cnt=1 and go to HEADER.
REQ-019 In HEADER, SHALL store accepted bytes at cnt 1..4 with this mapping:
- byte0 = vpi[11:4]
- byte1 = {vpi[3:0], vci[15:12]}
- byte2 = vci[11:4]
- byte3 = {vci[3:0], clp, pt[2:0]}
- byte4 = hec
After storing byte 4, SHALL go to PAYLOAD with cnt=5.
REQ-020 In PAYLOAD, SHALL store the accepted byte at cnt 5..52 as payload byte cnt-5; after byte 52, SHALL go to DELIVER.
REQ-021 SHALL compute the CRC-8 (x^8+x^2+x+1, initial value 0, MSB first) incrementally over header bytes 0..3.
REQ-022 On entry to DELIVER, SHALL set hec_err = HEC_CHECK && (crc ^ HEC_COSET) != hec.
REQ-023 In DELIVER, SHALL hold clav=0 and valid=1, with the cell outputs and hec_err stable.
REQ-024 valid SHALL rise on the edge after the edge that accepts byte 52: 1 cycle of latency.
REQ-025 In DELIVER, on a rising edge with ready=1, SHALL clear valid and go to IDLE; clav SHALL return to 1 on that same edge.
REQ-026 ready SHALL be ignored outside DELIVER.
REQ-027 An accepted byte with soc=1 in HEADER or PAYLOAD SHALL:
- pulse sync_err for one cycle;
- restart the cell with that byte as header byte 0, cnt=1, state HEADER;
- clear the CRC.
REQ-028 Accepted bytes in DELIVER (a transmitter protocol violation) SHALL be ignored, with no change to the outputs.
REQ-029 clav, valid, hec_err and sync_err SHALL be registered outputs; the cell outputs SHALL be registers written only on byte acceptance.
REQ-030 cnt SHALL never exceed 52; the counter SHALL not wrap.

Reset
REQ-031 While reset_n=0, SHALL force:
- state = IDLE;
- cnt = 0;
- CRC = 0;
- clav = 0, valid = 0, hec_err = 0, sync_err = 0;
- vpi, vci, clp, pt, hec and payload = 0.
REQ-032 clav SHALL rise to 1 on the first rising clk_in after reset_n deasserts.
REQ-033 Assertion of reset_n mid-cell or in DELIVER SHALL discard the partial or presented cell with no sync_err pulse.

Verification
REQ-034 Clean cell, streamed with en=0 every cycle:
- stimulus: header 12 34 56 78, HEC = (CRC of those 4 bytes) ^ 55, payload 00..2F;
- required: valid rises 1 cycle after byte 52; vpi=12'h123, vci=16'h4567, clp=1, pt=3'b000, payload[383:376]=00, payload[7:0]=2F, hec_err=0.
REQ-035 HEC error:
- stimulus: header 00 00 00 00 with HEC 54 (correct value is 55);
- required: hec_err=1 while valid=1; with HEC 55, hec_err=0.
REQ-036 Stall:
- stimulus: en=1 for 3 cycles between payload bytes 10 and 11;
- required: the cell is assembled correctly and valid rises 3 cycles later than in REQ-034.
REQ-037 Resync:
- stimulus: soc=1 on accepted byte 20 of a cell;
- required: sync_err pulses for exactly 1 cycle; the new cell starting at that byte is delivered intact.
REQ-038 Backpressure:
- stimulus: ready held at 0 for 10 cycles;
- required: valid=1, clav=0 and outputs stable for the whole interval; on the ready=1 edge valid=0 and clav=1.
REQ-039 Reset mid-payload:
- stimulus: reset_n low during byte 30;
- required: all outputs 0 during reset, clav=1 one edge after release, and the next soc cell is received cleanly.
